// File: rtl/alu_ctrl_decode_stage_if.sv
// ============================================================================
// alu_ctrl_decode_stage_if : handshake and decoded-control bundle for the
// decode stage. Revision 1.0
// ============================================================================
`default_nettype none

interface alu_ctrl_decode_stage_if;
   logic [31:0] In_instr;
   logic [31:0] In_pc;
   logic        In_valid;
   logic        In_ready;
   logic        Out_valid;
   logic        Out_ready;
   logic        Flush;
   logic [4:0]  Control;
   logic        Sel_A;
   logic        Sel_B;
   logic [31:0] Imm;
   logic [4:0]  Rd;
   logic [4:0]  Rs1;
   logic [4:0]  Rs2;
   logic [31:0] Pc_out;
   logic        RegWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        Branch;
   logic        Jump;
   logic        Illegal;

   modport master (
      output In_instr, In_pc, In_valid, Out_ready, Flush,
      input  In_ready, Out_valid, Control, Sel_A, Sel_B, Imm, Rd, Rs1, Rs2,
             Pc_out, RegWrite, MemRead, MemWrite, Branch, Jump, Illegal
   );

   modport slave (
      input  In_instr, In_pc, In_valid, Out_ready, Flush,
      output In_ready, Out_valid, Control, Sel_A, Sel_B, Imm, Rd, Rs1, Rs2,
             Pc_out, RegWrite, MemRead, MemWrite, Branch, Jump, Illegal
   );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_decode_stage.sv
// ============================================================================
// alu_ctrl_decode_stage : RV32I decode to ALU control, one registered slot
// with valid/ready handshake. Revision 1.0
// ============================================================================
`default_nettype none

module alu_ctrl_decode_stage (
   input  wire logic CLK,
   input  wire logic RST_N,
   alu_ctrl_decode_stage_if.slave bus
);

   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_branch = 7'b1100011;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;

   localparam logic [4:0] c_alu_add  = 5'b00000;
   localparam logic [4:0] c_alu_sub  = 5'b00001;
   localparam logic [4:0] c_alu_sll  = 5'b00010;
   localparam logic [4:0] c_alu_slt  = 5'b00011;
   localparam logic [4:0] c_alu_sltu = 5'b00100;
   localparam logic [4:0] c_alu_xor  = 5'b00101;
   localparam logic [4:0] c_alu_srl  = 5'b00110;
   localparam logic [4:0] c_alu_sra  = 5'b00111;
   localparam logic [4:0] c_alu_or   = 5'b01000;
   localparam logic [4:0] c_alu_and  = 5'b01001;
   localparam logic [4:0] c_alu_passb = 5'b01010;
   localparam logic [4:0] c_alu_beq  = 5'b01011;
   localparam logic [4:0] c_alu_bne  = 5'b01100;
   localparam logic [4:0] c_alu_blt  = 5'b01101;
   localparam logic [4:0] c_alu_bge  = 5'b01110;
   localparam logic [4:0] c_alu_bltu = 5'b01111;
   localparam logic [4:0] c_alu_bgeu = 5'b10000;

   localparam logic [6:0] c_f7_base = 7'b0000000;
   localparam logic [6:0] c_f7_alt  = 7'b0100000;

   typedef struct packed {
      logic [4:0]  control;
      logic        sel_a;
      logic        sel_b;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] pc;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } dec_t;

   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] imm_sh;
   logic [4:0]  alu_base;

   dec_t dec_comb;
   logic legal;
   logic accept;
   logic in_ready;

   dec_t dec_d, dec_q;
   logic valid_d, valid_q;

   assign instr  = bus.In_instr;
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_sh = {27'b0, instr[24:20]};

   // Shared funct3 map for OP and OP-IMM; funct7 qualifiers are applied per opcode.
   always_comb begin
      alu_base = c_alu_add;
      case (funct3)
         3'b000:  alu_base = c_alu_add;
         3'b001:  alu_base = c_alu_sll;
         3'b010:  alu_base = c_alu_slt;
         3'b011:  alu_base = c_alu_sltu;
         3'b100:  alu_base = c_alu_xor;
         3'b101:  alu_base = c_alu_srl;
         3'b110:  alu_base = c_alu_or;
         default: alu_base = c_alu_and;
      endcase
   end

   always_comb begin
      dec_comb     = '0;
      dec_comb.rd  = instr[11:7];
      dec_comb.rs1 = instr[19:15];
      dec_comb.rs2 = instr[24:20];
      dec_comb.pc  = bus.In_pc;
      legal        = 1'b1;

      case (opcode)
         c_opc_op: begin
            dec_comb.reg_write = 1'b1;
            if (funct7 == c_f7_base) begin
               dec_comb.control = alu_base;
            end else if (funct7 == c_f7_alt && funct3 == 3'b000) begin
               dec_comb.control = c_alu_sub;
            end else if (funct7 == c_f7_alt && funct3 == 3'b101) begin
               dec_comb.control = c_alu_sra;
            end else begin
               legal = 1'b0;
            end
         end
         c_opc_op_imm: begin
            dec_comb.reg_write = 1'b1;
            dec_comb.sel_b     = 1'b1;
            dec_comb.control   = alu_base;
            dec_comb.imm       = imm_i;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_comb.imm = imm_sh;
               if (funct3 == 3'b101 && funct7 == c_f7_alt) begin
                  dec_comb.control = c_alu_sra;
               end else if (funct7 != c_f7_base) begin
                  legal = 1'b0;
               end
            end
         end
         c_opc_lui: begin
            dec_comb.control   = c_alu_passb;
            dec_comb.sel_b     = 1'b1;
            dec_comb.imm       = imm_u;
            dec_comb.reg_write = 1'b1;
         end
         c_opc_auipc: begin
            dec_comb.sel_a     = 1'b1;
            dec_comb.sel_b     = 1'b1;
            dec_comb.imm       = imm_u;
            dec_comb.reg_write = 1'b1;
         end
         c_opc_load: begin
            dec_comb.sel_b     = 1'b1;
            dec_comb.imm       = imm_i;
            dec_comb.mem_read  = 1'b1;
            dec_comb.reg_write = 1'b1;
         end
         c_opc_store: begin
            dec_comb.sel_b     = 1'b1;
            dec_comb.imm       = imm_s;
            dec_comb.mem_write = 1'b1;
         end
         c_opc_branch: begin
            dec_comb.branch = 1'b1;
            dec_comb.imm    = imm_b;
            case (funct3)
               3'b000:  dec_comb.control = c_alu_beq;
               3'b001:  dec_comb.control = c_alu_bne;
               3'b100:  dec_comb.control = c_alu_blt;
               3'b101:  dec_comb.control = c_alu_bge;
               3'b110:  dec_comb.control = c_alu_bltu;
               3'b111:  dec_comb.control = c_alu_bgeu;
               default: legal = 1'b0;
            endcase
         end
         c_opc_jal: begin
            dec_comb.sel_a     = 1'b1;
            dec_comb.sel_b     = 1'b1;
            dec_comb.imm       = imm_j;
            dec_comb.jump      = 1'b1;
            dec_comb.reg_write = 1'b1;
         end
         c_opc_jalr: begin
            dec_comb.sel_b     = 1'b1;
            dec_comb.imm       = imm_i;
            dec_comb.jump      = 1'b1;
            dec_comb.reg_write = 1'b1;
         end
         default: legal = 1'b0;
      endcase

      // Illegal entries still travel downstream, but must not cause side effects.
      if (!legal) begin
         dec_comb.control   = c_alu_add;
         dec_comb.sel_a     = 1'b0;
         dec_comb.sel_b     = 1'b0;
         dec_comb.imm       = '0;
         dec_comb.reg_write = 1'b0;
         dec_comb.mem_read  = 1'b0;
         dec_comb.mem_write = 1'b0;
         dec_comb.branch    = 1'b0;
         dec_comb.jump      = 1'b0;
         dec_comb.illegal   = 1'b1;
      end

      if (dec_comb.rd == 5'd0) begin
         dec_comb.reg_write = 1'b0;
      end
   end

   assign in_ready = !valid_q || bus.Out_ready;
   assign accept   = bus.In_valid && in_ready;

   always_comb begin
      dec_d   = dec_q;
      valid_d = valid_q;
      if (bus.Flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
         dec_d   = dec_comb;
      end else if (bus.Out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q <= 1'b0;
         dec_q   <= '0;
      end else begin
         valid_q <= valid_d;
         dec_q   <= dec_d;
      end
   end

   assign bus.In_ready  = in_ready;
   assign bus.Out_valid = valid_q;
   assign bus.Control   = dec_q.control;
   assign bus.Sel_A     = dec_q.sel_a;
   assign bus.Sel_B     = dec_q.sel_b;
   assign bus.Imm       = dec_q.imm;
   assign bus.Rd        = dec_q.rd;
   assign bus.Rs1       = dec_q.rs1;
   assign bus.Rs2       = dec_q.rs2;
   assign bus.Pc_out    = dec_q.pc;
   assign bus.RegWrite  = dec_q.reg_write;
   assign bus.MemRead   = dec_q.mem_read;
   assign bus.MemWrite  = dec_q.mem_write;
   assign bus.Branch    = dec_q.branch;
   assign bus.Jump      = dec_q.jump;
   assign bus.Illegal   = dec_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_decode_stage.sv
// ============================================================================
// tb_alu_ctrl_decode_stage : directed vector table plus handshake, flush and
// reset sequences for alu_ctrl_decode_stage. Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl_decode_stage;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   alu_ctrl_decode_stage_if bus_if ();

   alu_ctrl_decode_stage dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  control;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        sel_a;
      logic        sel_b;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic valid, input logic oready, input logic flush);
      bus_if.In_instr  = instr;
      bus_if.In_pc     = pc;
      bus_if.In_valid  = valid;
      bus_if.Out_ready = oready;
      bus_if.Flush     = flush;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_vec(input vec_t v, input string tag);
      chk({tag, ".valid"},   {31'b0, bus_if.Out_valid}, 32'd1);
      chk({tag, ".control"}, {27'b0, bus_if.Control},   {27'b0, v.control});
      chk({tag, ".rd"},      {27'b0, bus_if.Rd},        {27'b0, v.rd});
      chk({tag, ".rs1"},     {27'b0, bus_if.Rs1},       {27'b0, v.instr[19:15]});
      chk({tag, ".rs2"},     {27'b0, bus_if.Rs2},       {27'b0, v.instr[24:20]});
      chk({tag, ".imm"},     bus_if.Imm,                v.imm);
      chk({tag, ".pc"},      bus_if.Pc_out,             v.pc);
      chk({tag, ".flags"},
          {23'b0, bus_if.Sel_A, bus_if.Sel_B, bus_if.RegWrite, bus_if.MemRead,
           bus_if.MemWrite, bus_if.Branch, bus_if.Jump, bus_if.Illegal, 1'b0},
          {23'b0, v.sel_a, v.sel_b, v.reg_write, v.mem_read,
           v.mem_write, v.branch, v.jump, v.illegal, 1'b0});
   endtask

   logic [4:0]  held_ctrl;
   logic [31:0] held_imm;
   logic [4:0]  held_rd;

   initial begin
      n_cmp = 0;
      n_err = 0;
      //            instr         pc            ctrl      rd     imm           sa    sb    rw    mr    mw    br    j     ill
      vecs[0]  = '{32'h002081B3, 32'h00000000, 5'b00000, 5'd3,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{32'h402081B3, 32'h00000004, 5'b00001, 5'd3,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h40335293, 32'h00000008, 5'b00111, 5'd5,  32'h00000003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{32'h0020D463, 32'h0000000C, 5'b01110, 5'd8,  32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{32'h123453B7, 32'h00000010, 5'b01010, 5'd7,  32'h12345000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{32'hFFFFFFFF, 32'h00000014, 5'b00000, 5'd31, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{32'hFFF00093, 32'h00000018, 5'b00000, 5'd1,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{32'h0040A103, 32'h0000001C, 5'b00000, 5'd2,  32'h00000004, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{32'hFE20AE23, 32'h00000020, 5'b00000, 5'd28, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{32'hFF9FF0EF, 32'h00000100, 5'b00000, 5'd1,  32'hFFFFFFF8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{32'h00008067, 32'h00000104, 5'b00000, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{32'h00001297, 32'h00000108, 5'b00000, 5'd5,  32'h00001000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{32'h0020A063, 32'h0000010C, 5'b00000, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{32'h402091B3, 32'h00000110, 5'b00000, 5'd3,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{32'h00209093, 32'h00000114, 5'b00010, 5'd1,  32'h00000002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{32'h0020E233, 32'h00000118, 5'b01000, 5'd4,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      #12;
      chk("reset.out_valid", {31'b0, bus_if.Out_valid}, 32'd0);
      chk("reset.in_ready",  {31'b0, bus_if.In_ready},  32'd1);
      chk("reset.control",   {27'b0, bus_if.Control},   32'd0);
      chk("reset.illegal",   {31'b0, bus_if.Illegal},   32'd0);
      chk("reset.imm",       bus_if.Imm,                32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back table with the consumer always ready.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].instr, vecs[i].pc, 1'b1, 1'b1, 1'b0);
         step();
         check_vec(vecs[i], $sformatf("vec%0d", i));
      end

      @(negedge clk);
      drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      chk("drain.out_valid", {31'b0, bus_if.Out_valid}, 32'd0);

      // Back-pressure: accept sub, stall 3 cycles offering lui, then release.
      @(negedge clk);
      drive(vecs[1].instr, vecs[1].pc, 1'b1, 1'b0, 1'b0);
      step();
      held_ctrl = bus_if.Control;
      held_imm  = bus_if.Imm;
      held_rd   = bus_if.Rd;
      check_vec(vecs[1], "stall.accept");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(vecs[4].instr, vecs[4].pc, 1'b1, 1'b0, 1'b0);
         #1;
         chk($sformatf("stall%0d.in_ready", c), {31'b0, bus_if.In_ready}, 32'd0);
         step();
         chk($sformatf("stall%0d.valid", c),   {31'b0, bus_if.Out_valid}, 32'd1);
         chk($sformatf("stall%0d.control", c), {27'b0, bus_if.Control}, {27'b0, held_ctrl});
         chk($sformatf("stall%0d.imm", c),     bus_if.Imm, held_imm);
         chk($sformatf("stall%0d.rd", c),      {27'b0, bus_if.Rd}, {27'b0, held_rd});
      end
      @(negedge clk);
      drive(vecs[4].instr, vecs[4].pc, 1'b1, 1'b1, 1'b0);
      #1;
      chk("release.in_ready", {31'b0, bus_if.In_ready}, 32'd1);
      step();
      check_vec(vecs[4], "release");

      // Flush with a simultaneous input discards both.
      @(negedge clk);
      drive(vecs[2].instr, vecs[2].pc, 1'b1, 1'b1, 1'b1);
      step();
      chk("flush.out_valid", {31'b0, bus_if.Out_valid}, 32'd0);

      // Flush kills a stalled entry as well.
      @(negedge clk);
      drive(vecs[3].instr, vecs[3].pc, 1'b1, 1'b0, 1'b0);
      step();
      chk("flush2.pre_valid", {31'b0, bus_if.Out_valid}, 32'd1);
      @(negedge clk);
      drive(vecs[3].instr, vecs[3].pc, 1'b0, 1'b0, 1'b1);
      step();
      chk("flush2.out_valid", {31'b0, bus_if.Out_valid}, 32'd0);

      // Asynchronous reset while holding an entry, away from any clock edge.
      @(negedge clk);
      drive(vecs[5].instr, vecs[5].pc, 1'b1, 1'b0, 1'b0);
      step();
      chk("areset.pre_valid", {31'b0, bus_if.Out_valid}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("areset.out_valid", {31'b0, bus_if.Out_valid}, 32'd0);
      chk("areset.illegal",   {31'b0, bus_if.Illegal},   32'd0);
      chk("areset.in_ready",  {31'b0, bus_if.In_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(vecs[0].instr, vecs[0].pc, 1'b1, 1'b1, 1'b0);
      step();
      check_vec(vecs[0], "post_reset");

      @(negedge clk);
      drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_decode_stage.md
ALU_CTRL_DECODE_STAGE -- requirements
Module: alu_ctrl_decode_stage

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state rises on posedge CLK.
REQ-002 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports In_instr (in, 32, RV32I instruction) and In_pc (in, 32, instruction address).
REQ-004 SHALL have ports In_valid (in, 1), In_ready (out, 1), Out_valid (out, 1) and Out_ready (in, 1), forming a valid/ready handshake.
REQ-005 SHALL have port Flush (in, 1), a synchronous kill of the held entry.
REQ-006 SHALL have ALU control output port Control, out, 5, with the ALU opcode encoding of REQ-013..REQ-018.
REQ-007 SHALL have outputs Sel_A (1, 1=PC else rs1), Sel_B (1, 1=Imm else rs2), Imm (32), Rd/Rs1/Rs2 (5 each), Pc_out (32), RegWrite, MemRead, MemWrite, Branch, Jump and Illegal (1 each).

Function
REQ-008 SHALL accept an instruction when In_valid && In_ready, and register its decode so it appears on the outputs with Out_valid=1 on the next edge (latency 1).
REQ-009 SHALL drive In_ready = !Out_valid || Out_ready combinationally, so a new accept can occur in the same cycle the held entry is consumed.
REQ-010 SHALL hold all outputs stable while Out_valid && !Out_ready.
REQ-011 SHALL clear Out_valid on the next edge when Out_ready=1 and no accept occurs.
REQ-012 SHALL give Flush priority over accept: a Flush cycle leaves Out_valid=0 next edge and discards any simultaneous input.
REQ-013 OP (0110011) SHALL map funct3/funct7 as follows: 000/0000000 add 00000; 000/0100000 sub 00001; 001 sll 00010; 010 slt 00011; 011 sltu 00100; 100 xor 00101; 101/0000000 srl 00110; 101/0100000 sra 00111; 110 or 01000; 111 and 01001. Any other funct7 is illegal.
REQ-014 OP-IMM (0010011) SHALL use the REQ-013 map without sub, with Sel_B=1 and an I-type Imm; slli/srli/srai SHALL check funct7, and Imm SHALL be the zero-extended shamt.
REQ-015 LUI (0110111) SHALL produce Control=01010 (pass B), Sel_B=1 and Imm = instr[31:12]<<12.
REQ-016 AUIPC SHALL produce add with Sel_A=1 and a U-type Imm. LOAD and STORE SHALL produce add with Sel_B=1, I-type or S-type Imm, and MemRead or MemWrite respectively.
REQ-017 BRANCH (1100011) SHALL set Branch=1, RegWrite=0, a B-type Imm, and map funct3: 000 EQ 01011; 001 NE 01100; 100 LT 01101; 101 GE 01110; 110 LTU 01111; 111 GEU 10000. funct3 010/011 is illegal.
REQ-018 JAL and JALR SHALL produce add with Jump=1, RegWrite=1 and a J-type or I-type Imm; JALR SHALL use Sel_A=0.
REQ-019 All immediates SHALL be sign-extended from instr[31], except shamt.
REQ-020 RegWrite SHALL be forced to 0 when Rd=0.
REQ-021 Any illegal or unknown opcode SHALL set Illegal=1, Control=00000, and clear RegWrite, MemRead, MemWrite, Branch and Jump.
REQ-022 Out_valid SHALL still assert for an illegal instruction, so it is carried downstream.

Reset
REQ-023 On RST_N=0, all outputs SHALL clear to 0 asynchronously, including Out_valid and Illegal; In_ready therefore reads 1.
REQ-024 A reset asserted mid-operation SHALL discard the held entry; the first accept after deassertion SHALL behave as from idle.

Verification
REQ-025 Apply 0x002081B3 (add x3,x1,x2) with Out_ready=1. Required one cycle later: Control=00000, Rd=3, RegWrite=1, Sel_B=0, Out_valid=1.
REQ-026 Apply 0x402081B3, then 0x40335293. Required: Control=00001; then Control=00111 with Imm=3 and Sel_B=1.
REQ-027 Apply 0x0020D463 (bge x1,x2,8). Required: Control=01110, Branch=1, Imm=8, RegWrite=0. Apply 0x123453B7. Required: Control=01010, Imm=0x12345000, Rd=7.
REQ-028 Apply 0xFFFFFFFF. Required: Illegal=1, Control=00000, all enables 0, Out_valid=1.
REQ-029 Hold Out_ready=0 for 3 cycles after an accept. Required: In_ready=0 and outputs constant. Then set Out_ready=1 with In_valid=1. Required: the new entry is accepted in the same cycle, with no bubble.
REQ-030 Assert Flush together with In_valid=1. Required: Out_valid=0 next cycle. Assert RST_N=0 while Out_valid=1. Required: Out_valid=0 immediately, without waiting for a clock edge.
